// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the forwarding/hazard logic.
//   AW        : register address width (slot record dest width)
//   AVAIL_W   : width of the slot "avail" field (min forwardable slot index)
//   FWD_*     : operand select encoding seen by the EX operand muxes
//   slot_t    : one in-flight register write tracked after ID
package pipeline_pkg;
  localparam int AW      = 5;
  localparam int AVAIL_W = 4;

  localparam int FWD_RF  = 0;  // operand comes from the register file
  localparam int FWD_MEM = 1;  // result held in slot 1 (EX/MEM)
  localparam int FWD_WB  = 2;  // result held in slot 2 (MEM/WB)

  typedef struct packed {
    logic               valid;
    logic [AW-1:0]      dest;
    logic [AVAIL_W-1:0] avail;
  } slot_t;
endpackage

// File: rtl/fwd_match_prio.sv
// Youngest-match priority encoder for one source operand.
//   slots    : forwardable slots 0..DEPTH-2 (slot 0 = EX)
//   src      : source register read by ID
//   useSrc   : ID actually reads src
//   hit      : some slot writes src
//   idx      : slot index of the youngest such write
//   notReady : youngest writer will not be forwardable when ID reaches EX
module fwd_match_prio
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  slot_t [DEPTH-2:0]  slots,
  input  logic  [AW-1:0]     src,
  input  logic               useSrc,
  output logic               hit,
  output logic  [SEL_W-1:0]  idx,
  output logic               notReady
);
  logic [DEPTH-2:0] laneHit;

  for (genvar k = 0; k < DEPTH - 1; k++) begin : gLane
    assign laneHit[k] = slots[k].valid && (slots[k].dest == src) &&
                        (src != '0) && useSrc;
  end

  // Scan oldest to youngest so the lowest matching slot overwrites the rest;
  // readiness is judged on that youngest writer only.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    notReady = 1'b0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (laneHit[k]) begin
        hit      = 1'b1;
        idx      = SEL_W'(k);
        notReady = (k + 1) < int'(slots[k].avail);
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit.
//   clk, reset           : clock, async active-high reset
//   id_*                 : decoded ID-stage instruction
//   flush                : kill the ID instruction
//   stall                : hold PC/IF-ID, bubble into EX (combinational)
//   fwd_a, fwd_b         : registered EX operand selects (0 = RF, k = slot k)
//   stall_cnt            : saturating count of stall cycles
module fwd_hazard_unit #(
  parameter int AW       = pipeline_pkg::AW,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a,
  output logic [SEL_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipeline_pkg::*;

  // The WB slot (DEPTH-1) is not stored: a writer there is visible through the
  // write-before-read register file, so it resolves to select 0 exactly like
  // no match at all.
  localparam int NS = DEPTH - 1;

  slot_t [NS-1:0]   slots;
  slot_t            issueSlot;
  logic             issue;
  logic             hitA, hitB, nrA, nrB;
  logic [SEL_W-1:0] idxA, idxB;

  fwd_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) uMatchA (
    .slots(slots), .src(id_rs), .useSrc(id_use_rs),
    .hit(hitA), .idx(idxA), .notReady(nrA)
  );

  fwd_match_prio #(.DEPTH(DEPTH), .SEL_W(SEL_W)) uMatchB (
    .slots(slots), .src(id_rt), .useSrc(id_use_rt),
    .hit(hitB), .idx(idxB), .notReady(nrB)
  );

  assign stall = id_valid & ~flush & (nrA | nrB);
  assign issue = id_valid & id_we & ~stall & ~flush & (id_rd != '0);

  always_comb begin
    issueSlot       = '0;
    issueSlot.valid = issue;
    issueSlot.dest  = id_rd;
    issueSlot.avail = id_is_load ? AVAIL_W'(1 + LOAD_LAT) : AVAIL_W'(1);
  end

  // Tracker shifts every edge, stalled or not; a stall shows up as a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots <= '0;
    end else begin
      slots[0] <= issueSlot;
      for (int k = 1; k < NS; k++) slots[k] <= slots[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a <= SEL_W'(FWD_RF);
      fwd_b <= SEL_W'(FWD_RF);
    end else if (stall || flush || !id_valid) begin
      fwd_a <= SEL_W'(FWD_RF);
      fwd_b <= SEL_W'(FWD_RF);
    end else begin
      fwd_a <= hitA ? idxA + SEL_W'(1) : SEL_W'(FWD_RF);
      fwd_b <= hitB ? idxB + SEL_W'(1) : SEL_W'(FWD_RF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          stall_cnt <= '0;
    else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule
